chunked_add_sequencer: RTL and testbench

//   Sequences one WIDTH-bit ripple adder slice over CHUNKS cycles to add two

---
 rtl/chunked_add_sequencer_if.sv | 30 +++
 rtl/chunked_add_sequencer.sv | 105 ++++++++++
 tb/tb_chunked_add_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/chunked_add_sequencer_if.sv
// Request/response bundle for the chunked adder sequencer.
// The master drives operands and consumes results; the slave is the sequencer.
interface chunked_add_sequencer_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CHUNKS = 4
);
  localparam int unsigned TW = WIDTH * CHUNKS;
  localparam int unsigned IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  logic          req_valid;
  logic          req_ready;
  logic [TW-1:0] req_a;
  logic [TW-1:0] req_b;
  logic          req_cin;
  logic          flush;
  logic          resp_valid;
  logic          resp_ready;
  logic [TW:0]   resp_sum;
  logic [IW-1:0] chunk_idx;

  modport master (
    output req_valid, req_a, req_b, req_cin, flush, resp_ready,
    input  req_ready, resp_valid, resp_sum, chunk_idx
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, flush, resp_ready,
    output req_ready, resp_valid, resp_sum, chunk_idx
  );
endinterface

// File: rtl/chunked_add_sequencer.sv
// Adds two WIDTH*CHUNKS-bit operands with a single WIDTH-bit adder slice,
// one chunk per cycle from the least-significant end, carry held between chunks.
module chunked_add_sequencer #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CHUNKS = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  chunked_add_sequencer_if.slave  bus
);
  localparam int unsigned TW = WIDTH * CHUNKS;
  localparam int unsigned SW = WIDTH + 1;
  localparam int unsigned IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_a;
  logic [TW-1:0] r_b;
  logic [TW-1:0] r_result;
  logic          r_carry;
  logic [IW-1:0] r_idx;
  logic          r_req_ready;
  logic          r_resp_valid;

  logic [31:0]    w_base;
  logic [WIDTH-1:0] w_a_chunk;
  logic [WIDTH-1:0] w_b_chunk;
  logic [SW-1:0]  w_slice;
  logic           w_last;

  // The single adder slice, steered by the chunk index.
  always_comb begin
    w_base    = 32'(r_idx) * 32'(WIDTH);
    w_a_chunk = r_a[w_base +: WIDTH];
    w_b_chunk = r_b[w_base +: WIDTH];
    w_slice   = SW'(w_a_chunk) + SW'(w_b_chunk) + SW'(r_carry);
    w_last    = (r_idx == IW'(CHUNKS - 1));
  end

  // Sequencer FSM; flush overrides every other event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_result     <= '0;
      r_carry      <= 1'b0;
      r_idx        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
    end else if (bus.flush) begin
      r_state      <= S_IDLE;
      r_carry      <= 1'b0;
      r_idx        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_a         <= bus.req_a;
            r_b         <= bus.req_b;
            r_carry     <= bus.req_cin;
            r_idx       <= '0;
            r_state     <= S_RUN;
            r_req_ready <= 1'b0;
          end
        end
        S_RUN: begin
          r_result[w_base +: WIDTH] <= w_slice[WIDTH-1:0];
          r_carry                   <= w_slice[WIDTH];
          if (w_last) begin
            r_idx        <= '0;
            r_state      <= S_DONE;
            r_resp_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        S_DONE: begin
          if (bus.resp_ready) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_sum   = {r_carry, r_result};
  assign bus.chunk_idx  = r_idx;
endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Randomized self-checking bench for chunked_add_sequencer (CHUNKS=4 and CHUNKS=1).
module tb_chunked_add_sequencer;
  localparam int unsigned W  = 8;
  localparam int unsigned C  = 4;
  localparam int unsigned TW = W * C;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  chunked_add_sequencer_if #(.WIDTH(W), .CHUNKS(C)) bus ();
  chunked_add_sequencer_if #(.WIDTH(W), .CHUNKS(1)) bus1 ();

  chunked_add_sequencer #(.WIDTH(W), .CHUNKS(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  chunked_add_sequencer #(.WIDTH(W), .CHUNKS(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: the whole-width sum, carry-out in the top bit.
  function automatic logic [TW:0] ref_sum(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                          input logic cin);
    return (TW+1)'(a) + (TW+1)'(b) + (TW+1)'(cin);
  endfunction

  task automatic accept(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic cin);
    chk("ready_before_accept", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_cin   = cin;
    step();
    bus.req_valid = 1'b0;
    bus.req_a     = $urandom();
    bus.req_b     = $urandom();
    bus.req_cin   = 1'($urandom());
    chk("ready_after_accept", 64'(bus.req_ready), 64'd0);
  endtask

  task automatic run_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic cin,
                        input int hold);
    logic [TW:0] exp;
    exp = ref_sum(a, b, cin);
    accept(a, b, cin);
    for (int k = 0; k < int'(C); k++) begin
      chk("chunk_idx", 64'(bus.chunk_idx), 64'(k));
      chk("valid_early", 64'(bus.resp_valid), 64'd0);
      step();
    end
    chk("valid_latency", 64'(bus.resp_valid), 64'd1);
    chk("sum", 64'(bus.resp_sum), 64'(exp));
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", 64'(bus.resp_valid), 64'd1);
      chk("hold_sum", 64'(bus.resp_sum), 64'(exp));
      chk("hold_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    chk("post_hs_valid", 64'(bus.resp_valid), 64'd0);
    chk("post_hs_ready", 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_cin = 1'b0;
    bus.flush = 1'b0; bus.resp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_a = '0; bus1.req_b = '0; bus1.req_cin = 1'b0;
    bus1.flush = 1'b0; bus1.resp_ready = 1'b0;
    #12;
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_sum", 64'(bus.resp_sum), 64'd0);
    chk("rst_idx", 64'(bus.chunk_idx), 64'd0);
    rst_n = 1'b1;
    step();

    // Directed cases
    run_op(32'h000000FF, 32'h00000001, 1'b0, 0);
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5);

    // Flush after two RUN edges
    accept(32'hDEADBEEF, 32'h01020304, 1'b1);
    step(); step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_ready", 64'(bus.req_ready), 64'd1);
    chk("flush_idx", 64'(bus.chunk_idx), 64'd0);
    for (int k = 0; k < int'(C) + 1; k++) begin
      chk("flush_no_valid", 64'(bus.resp_valid), 64'd0);
      step();
    end
    run_op(32'h12345678, 32'h11111111, 1'b0, 1);

    // Flush in DONE wins over resp_ready
    accept(32'h00000001, 32'h00000002, 1'b0);
    for (int k = 0; k < int'(C); k++) step();
    chk("done_reached", 64'(bus.resp_valid), 64'd1);
    bus.flush = 1'b1; bus.resp_ready = 1'b1;
    step();
    bus.flush = 1'b0; bus.resp_ready = 1'b0;
    chk("done_flush_valid", 64'(bus.resp_valid), 64'd0);
    chk("done_flush_ready", 64'(bus.req_ready), 64'd1);

    // Flush together with req_valid in IDLE: not accepted
    bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_a = 32'h5; bus.req_b = 32'h6;
    step();
    bus.flush = 1'b0; bus.req_valid = 1'b0;
    chk("idle_flush_ready", 64'(bus.req_ready), 64'd1);
    for (int k = 0; k < int'(C) + 1; k++) step();
    chk("idle_flush_no_valid", 64'(bus.resp_valid), 64'd0);

    // Asynchronous reset mid-RUN
    accept(32'hCAFEF00D, 32'h13572468, 1'b0);
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.resp_valid), 64'd0);
    chk("arst_ready", 64'(bus.req_ready), 64'd1);
    chk("arst_sum", 64'(bus.resp_sum), 64'd0);
    chk("arst_idx", 64'(bus.chunk_idx), 64'd0);
    #2;
    rst_n = 1'b1;
    step();
    run_op(32'h89ABCDEF, 32'h76543210, 1'b1, 0);

    // Randomized operations
    for (int n = 0; n < 25; n++) begin
      run_op($urandom(), $urandom(), 1'($urandom()), int'($urandom_range(0, 3)));
    end

    // Single-chunk instance
    bus1.req_valid = 1'b1; bus1.req_a = 8'hFF; bus1.req_b = 8'h01; bus1.req_cin = 1'b1;
    step();
    bus1.req_valid = 1'b0; bus1.req_a = 8'h00; bus1.req_b = 8'h00;
    chk("c1_not_yet", 64'(bus1.resp_valid), 64'd0);
    step();
    chk("c1_valid", 64'(bus1.resp_valid), 64'd1);
    chk("c1_sum", 64'(bus1.resp_sum), 64'h101);
    bus1.resp_ready = 1'b1;
    step();
    bus1.resp_ready = 1'b0;
    chk("c1_ready", 64'(bus1.req_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
